board_memory_server: RTL and testbench

Owns the 64-square chess board store and serves the memory side of the move-validation interface. Each cycle it answers square reads from the validators with the occupying piece. When the controller commits a validated move, it applies the move as a sequenced read-modify-write. It also loads the starting position after reset or on request, and provides a second read-only port for the display path.

---
 rtl/board_memory_server.sv | 160 ++++++++++++++++
 tb/tb_board_memory_server.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/board_memory_server.sv
// Chess board store with validator/display read ports and sequenced move commit.
// Optional BOARD_PROMOTION_EN: pawns reaching the last rank are written as queens.
module board_memory_server (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] address_validator,
  output logic [3:0] piece_read,
  input  logic [5:0] address_display,
  output logic [3:0] piece_display,
  input  logic       new_game,
  input  logic       commit_start,
  input  logic [2:0] origin_x,
  input  logic [2:0] origin_y,
  input  logic [2:0] destination_x,
  input  logic [2:0] destination_y,
  output logic       commit_complete,
  output logic [3:0] captured_piece,
  output logic       busy
);

  // state   | meaning
  // INIT    | sweep counter loads start position, one square per cycle
  // IDLE    | serving reads, accepting new_game / commit_start
  // CAPTURE | latch moving piece and destination contents
  // WR_DST  | write moving piece to destination
  // WR_ORG  | clear origin, pulse commit_complete
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_CAPTURE, S_WR_DST, S_WR_ORG} state_t;

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] org_q, org_d;
  logic [5:0] dst_q, dst_d;
  logic [3:0] mover_q, mover_d;
  logic [3:0] captured_q, captured_d;
  logic [3:0] read_q, disp_q;
  logic [3:0] board [64];

  logic       we;
  logic [5:0] waddr;
  logic [3:0] wdata;

  function automatic logic [3:0] start_piece(input logic [5:0] a);
    logic [3:0] back;
    logic [3:0] p;
    back = 4'd0;
    p    = 4'd0;
    case (a[5:3])
      3'd0, 3'd7: back = 4'd4;
      3'd1, 3'd6: back = 4'd2;
      3'd2, 3'd5: back = 4'd3;
      3'd3:       back = 4'd5;
      default:    back = 4'd6;
    endcase
    case (a[2:0])
      3'd0:    p = back;
      3'd1:    p = 4'd1;
      3'd6:    p = 4'd7;
      3'd7:    p = back + 4'd6;
      default: p = 4'd0;
    endcase
    return p;
  endfunction

  function automatic logic [3:0] place_piece(input logic [3:0] pc, input logic [2:0] y);
`ifdef BOARD_PROMOTION_EN
    if (pc == 4'd1 && y == 3'd7) return 4'd5;
    if (pc == 4'd7 && y == 3'd0) return 4'd11;
    return pc;
`else
    logic [2:0] unused_y;
    unused_y = y;
    return pc;
`endif
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    org_d      = org_q;
    dst_d      = dst_q;
    mover_d    = mover_q;
    captured_d = captured_q;
    we         = 1'b0;
    waddr      = cnt_q;
    wdata      = start_piece(cnt_q);
    case (state_q)
      S_INIT: begin
        we    = 1'b1;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd63) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (new_game) begin
          state_d = S_INIT;
          cnt_d   = 6'd0;
        end else if (commit_start) begin
          org_d   = {origin_x, origin_y};
          dst_d   = {destination_x, destination_y};
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        mover_d    = board[org_q];
        // A null move reports no capture.
        captured_d = (org_q == dst_q) ? 4'd0 : board[dst_q];
        state_d    = S_WR_DST;
      end
      S_WR_DST: begin
        we      = (org_q != dst_q);
        waddr   = dst_q;
        wdata   = place_piece(mover_q, dst_q[2:0]);
        state_d = S_WR_ORG;
      end
      S_WR_ORG: begin
        we      = (org_q != dst_q);
        waddr   = org_q;
        wdata   = 4'd0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_INIT;
      cnt_q      <= 6'd0;
      org_q      <= 6'd0;
      dst_q      <= 6'd0;
      mover_q    <= 4'd0;
      captured_q <= 4'd0;
      read_q     <= 4'd0;
      disp_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      org_q      <= org_d;
      dst_q      <= dst_d;
      mover_q    <= mover_d;
      captured_q <= captured_d;
      read_q     <= (state_q == S_INIT) ? 4'd0 : board[address_validator];
      disp_q     <= (state_q == S_INIT) ? 4'd0 : board[address_display];
    end
  end

  // Array kept out of the reset domain so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (we) board[waddr] <= wdata;
  end

  assign piece_read      = read_q;
  assign piece_display   = disp_q;
  assign captured_piece  = captured_q;
  assign busy            = (state_q != S_IDLE);
  assign commit_complete = (state_q == S_WR_ORG);

endmodule

// File: tb/tb_board_memory_server.sv
// Self-checking bench for board_memory_server: start-position table, directed commits,
// randomized commits against an array model, reset/new_game reload sequences.
module tb_board_memory_server;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] address_validator, address_display;
  logic [3:0] piece_read, piece_display, captured_piece;
  logic       new_game, commit_start, commit_complete, busy;
  logic [2:0] origin_x, origin_y, destination_x, destination_y;

  int errors = 0;
  int checks = 0;
  int mb [64];
  int back_row [8];
  bit promo_on;

  typedef struct {
    logic [5:0] addr;
    int         exp;
  } vec_t;
  vec_t vecs [10];

  board_memory_server dut (
    .clk(clk), .reset(reset),
    .address_validator(address_validator), .piece_read(piece_read),
    .address_display(address_display), .piece_display(piece_display),
    .new_game(new_game), .commit_start(commit_start),
    .origin_x(origin_x), .origin_y(origin_y),
    .destination_x(destination_x), .destination_y(destination_y),
    .commit_complete(commit_complete), .captured_piece(captured_piece), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sq(input int x, input int y);
    return x * 8 + y;
  endfunction

  task automatic model_reset();
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) begin
        if (y == 0)      mb[sq(x, y)] = back_row[x];
        else if (y == 1) mb[sq(x, y)] = 1;
        else if (y == 6) mb[sq(x, y)] = 7;
        else if (y == 7) mb[sq(x, y)] = back_row[x] + 6;
        else             mb[sq(x, y)] = 0;
      end
  endtask

  task automatic model_commit(input int ox, input int oy, input int dx, input int dy,
                              output int cap);
    int p;
    if (ox == dx && oy == dy) begin
      cap = 0;
    end else begin
      cap = mb[sq(dx, dy)];
      p = mb[sq(ox, oy)];
      if (promo_on && p == 1 && dy == 7) p = 5;
      if (promo_on && p == 7 && dy == 0) p = 11;
      mb[sq(dx, dy)] = p;
      mb[sq(ox, oy)] = 0;
    end
  endtask

  function automatic int read_sq(input int x, input int y);
    return 0;
  endfunction

  task automatic read_at(input int x, input int y, output int v);
    address_validator = 6'(sq(x, y));
    tick();
    v = piece_read;
  endtask

  task automatic verify_all(input string tag);
    for (int a = 0; a < 64; a++) begin
      address_validator = 6'(a);
      address_display   = 6'(63 - a);
      tick();
      chk({tag, "_read"}, piece_read, mb[a]);
      chk({tag, "_disp"}, piece_display, mb[63 - a]);
    end
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    address_validator = 6'(sq(4, 0));
    while (busy && n < 200) begin
      if (n == 10) chk({tag, "_init_read_zero"}, piece_read, 0);
      if (commit_complete) chk({tag, "_init_no_complete"}, commit_complete, 0);
      tick();
      n++;
    end
    chk({tag, "_init_cycles"}, n, 64);
  endtask

  task automatic commit(input int ox, input int oy, input int dx, input int dy,
                        output int cap);
    origin_x = 3'(ox); origin_y = 3'(oy);
    destination_x = 3'(dx); destination_y = 3'(dy);
    commit_start = 1'b1;
    tick();
    commit_start = 1'b0;
    model_commit(ox, oy, dx, dy, cap);
    chk("c1_busy", busy, 1);
    chk("c1_cc", commit_complete, 0);
    tick();
    chk("c2_cc", commit_complete, 0);
    tick();
    chk("c3_cc", commit_complete, 1);
    tick();
    chk("c4_cc", commit_complete, 0);
    chk("c4_busy", busy, 0);
    chk("captured", captured_piece, cap);
  endtask

  initial begin
    int v, cap, pulses;
`ifdef BOARD_PROMOTION_EN
    promo_on = 1'b1;
`else
    promo_on = 1'b0;
`endif
    back_row[0] = 4; back_row[1] = 2; back_row[2] = 3; back_row[3] = 5;
    back_row[4] = 6; back_row[5] = 3; back_row[6] = 2; back_row[7] = 4;

    vecs[0] = '{6'o40, 6};  vecs[1] = '{6'o47, 12}; vecs[2] = '{6'o23, 0};
    vecs[3] = '{6'o00, 4};  vecs[4] = '{6'o30, 5};  vecs[5] = '{6'o77, 10};
    vecs[6] = '{6'o11, 1};  vecs[7] = '{6'o56, 7};  vecs[8] = '{6'o67, 8};
    vecs[9] = '{6'o27, 9};

    reset = 1'b0; new_game = 1'b0; commit_start = 1'b0;
    origin_x = 0; origin_y = 0; destination_x = 0; destination_y = 0;
    address_validator = 0; address_display = 0;
    #1;
    repeat (3) tick();
    chk("rst_busy", busy, 1);
    chk("rst_read", piece_read, 0);
    chk("rst_disp", piece_display, 0);
    chk("rst_cap", captured_piece, 0);
    chk("rst_cc", commit_complete, 0);
    reset = 1'b1;
    wait_init("boot");
    model_reset();

    foreach (vecs[i]) begin
      address_validator = vecs[i].addr;
      address_display   = vecs[i].addr;
      tick();
      chk("start_read", piece_read, vecs[i].exp);
      chk("start_disp", piece_display, vecs[i].exp);
    end

    commit(4, 1, 4, 3, cap);
    chk("pawn_cap", captured_piece, 0);
    read_at(4, 3, v); chk("pawn_dst", v, 1);
    read_at(4, 1, v); chk("pawn_org", v, 0);

    commit(4, 3, 4, 3, cap);
    chk("null_cap", captured_piece, 0);
    read_at(4, 3, v); chk("null_sq", v, 1);

    commit(1, 7, 3, 4, cap);
    commit(3, 0, 3, 4, cap);
    chk("queen_cap", captured_piece, 8);
    read_at(3, 4, v); chk("queen_dst", v, 5);
    read_at(3, 0, v); chk("queen_org", v, 0);

    commit(0, 1, 0, 6, cap);
    commit(0, 6, 0, 7, cap);
    chk("promo_cap", captured_piece, 10);
    read_at(0, 7, v); chk("promo_dst", v, promo_on ? 5 : 1);

    // Late commit_start in CAPTURE and new_game in WR_DST must be dropped.
    origin_x = 2; origin_y = 1; destination_x = 2; destination_y = 3;
    commit_start = 1'b1;
    tick();
    model_commit(2, 1, 2, 3, cap);
    origin_x = 5; origin_y = 1; destination_x = 5; destination_y = 3;
    tick();
    commit_start = 1'b0;
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    pulses = int'(commit_complete);
    for (int i = 0; i < 10; i++) begin
      tick();
      pulses += int'(commit_complete);
    end
    chk("ignore_pulses", pulses, 1);
    chk("ignore_busy", busy, 0);
    verify_all("ignore");

    for (int i = 0; i < 25; i++)
      commit($urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 7), cap);
    verify_all("random");

    // Reset during WR_DST aborts the move and reloads the board.
    commit(6, 0, 5, 2, cap);
    origin_x = 3; origin_y = 1; destination_x = 3; destination_y = 3;
    commit_start = 1'b1;
    tick();
    commit_start = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_cc", commit_complete, 0);
    chk("mid_rst_cap", captured_piece, 0);
    chk("mid_rst_read", piece_read, 0);
    chk("mid_rst_disp", piece_display, 0);
    tick(); tick();
    reset = 1'b1;
    wait_init("rst");
    model_reset();
    verify_all("reload");

    // new_game and commit_start together: reload wins.
    commit(1, 0, 2, 2, cap);
    origin_x = 4; origin_y = 1; destination_x = 4; destination_y = 3;
    commit_start = 1'b1;
    new_game = 1'b1;
    tick();
    commit_start = 1'b0;
    new_game = 1'b0;
    chk("ng_busy", busy, 1);
    wait_init("ng");
    model_reset();
    verify_all("newgame");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
